led_palette_fader: RTL and testbench

- Upstream stage of the LED PWM driver.
- Holds a target palette per LED and exposes the current palette as the packed 8-bit-per-filament value buses that the PWM driver consumes.
- Moves each current value toward its target by a fixed step on a periodic fade tick, so colour changes appear as smooth fades rather than jumps.
- Targets are written one LED at a time over a valid/ready load port; each load may optionally bypass the fade.

---
 rtl/led_palette_fader.sv | 158 +++++++++++++++
 tb/tb_led_palette_fader.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_palette_fader.sv
// led_palette_fader: holds a target palette per LED and moves the current
// palette toward it by a bounded step on each fade tick. Targets arrive one
// LED at a time through a two-stage (accept, commit) load port.

// One filament: current/target pair with clamped stepping toward target.
module led_palette_fader_filament #(
    parameter int STEP = 1
) (
    input  logic       i_clk,
    input  logic       i_arst_n,
    input  logic       tick,
    input  logic       wr_en,
    input  logic       wr_instant,
    input  logic [7:0] wr_val,
    output logic [7:0] cur,
    output logic       neq
);
    logic [7:0] tgt_q, cur_q, step_nxt;
    logic [8:0] cur9, tgt9, gap, stp;

    assign cur9 = {1'b0, cur_q};
    assign tgt9 = {1'b0, tgt_q};
    assign stp  = 9'(STEP);

    // Next value after one tick: land exactly on target when within one step
    always_comb begin
        step_nxt = cur_q;
        gap      = '0;
        if (cur9 < tgt9) begin
            gap      = tgt9 - cur9;
            step_nxt = (gap <= stp) ? tgt_q : cur_q + stp[7:0];
        end else if (cur9 > tgt9) begin
            gap      = cur9 - tgt9;
            step_nxt = (gap <= stp) ? tgt_q : cur_q - stp[7:0];
        end
    end

    // Step uses the pre-commit target; an instant commit overrides the step
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            tgt_q <= '0;
            cur_q <= '0;
        end else begin
            if (wr_en) tgt_q <= wr_val;
            if (wr_en && wr_instant) cur_q <= wr_val;
            else if (tick)           cur_q <= step_nxt;
        end
    end

    assign cur = cur_q;
    assign neq = (cur_q != tgt_q);
endmodule

module led_palette_fader #(
    parameter  int parm_color_led_count          = 4,
    parameter  int parm_basic_led_count          = 4,
    parameter  int parm_FCLK                     = 40_000_000,
    parameter  int parm_step_period_microseconds = 1000,
    parameter  int parm_step_size                = 1,
    localparam int c_max_cnt = (parm_color_led_count > parm_basic_led_count) ?
                               parm_color_led_count : parm_basic_led_count,
    localparam int IW        = (c_max_cnt > 1) ? $clog2(c_max_cnt) : 1
) (
    input  logic                              i_clk,
    input  logic                              i_arst_n,
    input  logic                              i_load_valid,
    output logic                              o_load_ready,
    input  logic                              i_load_is_basic,
    input  logic [IW-1:0]                     i_load_index,
    input  logic [23:0]                       i_load_value,
    input  logic                              i_load_instant,
    output logic [8*parm_color_led_count-1:0] o_color_led_red_value,
    output logic [8*parm_color_led_count-1:0] o_color_led_green_value,
    output logic [8*parm_color_led_count-1:0] o_color_led_blue_value,
    output logic [8*parm_basic_led_count-1:0] o_basic_led_lumin_value,
    output logic                              o_fade_busy
);
    localparam int c_step_ticks = parm_FCLK / 1_000_000 * parm_step_period_microseconds;
    localparam int CW = (c_step_ticks > 1) ? $clog2(c_step_ticks) : 1;

    typedef struct packed {
        logic          is_basic;
        logic [IW-1:0] idx;
        logic [23:0]   val;
        logic          inst;
    } load_req_t;

    logic [CW-1:0] cnt_q;
    logic          tick;
    logic          ready_q, stage_vld, busy_q, accept;
    load_req_t     stage_q;

    logic [parm_color_led_count-1:0][2:0][7:0] color_cur;
    logic [parm_color_led_count-1:0][2:0]      color_neq;
    logic [parm_basic_led_count-1:0][7:0]      basic_cur;
    logic [parm_basic_led_count-1:0]           basic_neq;

    assign tick   = (cnt_q == '0);
    assign accept = i_load_valid && ready_q;

    // Free-running down-counter; one tick every c_step_ticks cycles
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) cnt_q <= CW'(c_step_ticks - 1);
        else           cnt_q <= tick ? CW'(c_step_ticks - 1) : cnt_q - 1'b1;
    end

    // Accept into the one-entry stage; ready drops for the commit cycle
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            ready_q   <= 1'b0;
            stage_vld <= 1'b0;
            stage_q   <= '0;
        end else begin
            ready_q   <= !accept;
            stage_vld <= accept;
            if (accept) stage_q <= '{i_load_is_basic, i_load_index, i_load_value, i_load_instant};
        end
    end

    // Colour LEDs: filament 0/1/2 = red/green/blue = value bits [23:16]/[15:8]/[7:0]
    for (genvar n = 0; n < parm_color_led_count; n++) begin : g_color
        logic wr;
        assign wr = stage_vld && !stage_q.is_basic && (stage_q.idx == IW'(n));
        for (genvar f = 0; f < 3; f++) begin : g_fil
            led_palette_fader_filament #(.STEP(parm_step_size)) u_fil (
                .i_clk(i_clk), .i_arst_n(i_arst_n), .tick(tick),
                .wr_en(wr), .wr_instant(stage_q.inst),
                .wr_val(stage_q.val[23-8*f -: 8]),
                .cur(color_cur[n][f]), .neq(color_neq[n][f])
            );
        end
        assign o_color_led_red_value[8*n +: 8]   = color_cur[n][0];
        assign o_color_led_green_value[8*n +: 8] = color_cur[n][1];
        assign o_color_led_blue_value[8*n +: 8]  = color_cur[n][2];
    end

    // Basic LEDs take luminance from the low byte only
    for (genvar n = 0; n < parm_basic_led_count; n++) begin : g_basic
        logic wr;
        assign wr = stage_vld && stage_q.is_basic && (stage_q.idx == IW'(n));
        led_palette_fader_filament #(.STEP(parm_step_size)) u_fil (
            .i_clk(i_clk), .i_arst_n(i_arst_n), .tick(tick),
            .wr_en(wr), .wr_instant(stage_q.inst),
            .wr_val(stage_q.val[7:0]),
            .cur(basic_cur[n]), .neq(basic_neq[n])
        );
        assign o_basic_led_lumin_value[8*n +: 8] = basic_cur[n];
    end

    // Busy reflects the previous cycle's cur/tgt comparison
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) busy_q <= 1'b0;
        else           busy_q <= (|color_neq) | (|basic_neq);
    end

    assign o_load_ready = ready_q;
    assign o_fade_busy  = busy_q;
endmodule

// File: tb/tb_led_palette_fader.sv
// Bench for led_palette_fader: two instances share one load port. dut_a is
// 4/4 LEDs with step 1, dut_b is 3/4 LEDs with step 16 (so colour index 3 is
// out of range). A per-edge behavioural model predicts every output.
module tb_led_palette_fader;
    logic        i_clk = 1'b0;
    logic        i_arst_n = 1'b0;
    logic        i_load_valid = 1'b0;
    logic        i_load_is_basic = 1'b0;
    logic [1:0]  i_load_index = '0;
    logic [23:0] i_load_value = '0;
    logic        i_load_instant = 1'b0;
    logic        rdy_a, rdy_b, busy_a, busy_b;
    logic [31:0] red_a, green_a, blue_a, basic_a, basic_b;
    logic [23:0] red_b, green_b, blue_b;

    int tests = 0;
    int fails = 0;

    always #5 i_clk = ~i_clk;

    led_palette_fader #(
        .parm_color_led_count(4), .parm_basic_led_count(4), .parm_FCLK(1_000_000),
        .parm_step_period_microseconds(4), .parm_step_size(1)
    ) dut_a (
        .i_clk(i_clk), .i_arst_n(i_arst_n), .i_load_valid(i_load_valid), .o_load_ready(rdy_a),
        .i_load_is_basic(i_load_is_basic), .i_load_index(i_load_index),
        .i_load_value(i_load_value), .i_load_instant(i_load_instant),
        .o_color_led_red_value(red_a), .o_color_led_green_value(green_a),
        .o_color_led_blue_value(blue_a), .o_basic_led_lumin_value(basic_a), .o_fade_busy(busy_a)
    );

    led_palette_fader #(
        .parm_color_led_count(3), .parm_basic_led_count(4), .parm_FCLK(1_000_000),
        .parm_step_period_microseconds(4), .parm_step_size(16)
    ) dut_b (
        .i_clk(i_clk), .i_arst_n(i_arst_n), .i_load_valid(i_load_valid), .o_load_ready(rdy_b),
        .i_load_is_basic(i_load_is_basic), .i_load_index(i_load_index),
        .i_load_value(i_load_value), .i_load_instant(i_load_instant),
        .o_color_led_red_value(red_b), .o_color_led_green_value(green_b),
        .o_color_led_blue_value(blue_b), .o_basic_led_lumin_value(basic_b), .o_fade_busy(busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Filament slots: colour LED n uses 3n+0/1/2 (r/g/b), basic LED n uses 12+n.
    int cur_m[2][16];
    int tgt_m[2][16];
    bit busy_m[2];
    bit ready_m = 1'b0;
    bit pend_m  = 1'b0;
    bit p_basic, p_inst;
    int p_idx;
    int p_val;
    int edge_m = 0;

    function automatic int ccnt(int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic int stepsz(int d);
        return (d == 0) ? 1 : 16;
    endfunction

    function automatic int step_to(int v, int t, int s);
        if (v < t) return v + ((t - v < s) ? t - v : s);
        if (v > t) return v - ((v - t < s) ? v - t : s);
        return v;
    endfunction

    function automatic bit hit_of(int d, int i, output int cv);
        int n;
        cv = 0;
        if (i < 12) begin
            n  = i / 3;
            cv = (p_val >> (16 - 8 * (i % 3))) & 255;
            return !p_basic && (p_idx == n) && (n < ccnt(d));
        end
        n  = i - 12;
        cv = p_val & 255;
        return p_basic && (p_idx == n);
    endfunction

    function automatic logic [31:0] exp_bus(int d, int k);
        logic [31:0] r;
        int cnt;
        r   = '0;
        cnt = (k == 3) ? 4 : ccnt(d);
        for (int n = 0; n < cnt; n++)
            r[8*n +: 8] = 8'((k == 3) ? cur_m[d][12+n] : cur_m[d][n*3+k]);
        return r;
    endfunction

    // Model advances on the same edges as the DUT; tick on every 4th edge after reset
    always @(posedge i_clk or negedge i_arst_n) begin : m_upd
        bit tick, hit, anyneq;
        int v, cv;
        if (!i_arst_n) begin
            for (int d = 0; d < 2; d++) begin
                busy_m[d] <= 1'b0;
                for (int i = 0; i < 16; i++) begin
                    cur_m[d][i] <= 0;
                    tgt_m[d][i] <= 0;
                end
            end
            ready_m <= 1'b0;
            pend_m  <= 1'b0;
            edge_m  <= 0;
        end else begin
            tick = ((edge_m + 1) % 4) == 0;
            for (int d = 0; d < 2; d++) begin
                anyneq = 1'b0;
                for (int i = 0; i < 16; i++) begin
                    hit = pend_m ? hit_of(d, i, cv) : 1'b0;
                    v   = cur_m[d][i];
                    if (tick) v = step_to(v, tgt_m[d][i], stepsz(d));
                    if (hit && p_inst) v = cv;
                    cur_m[d][i] <= v;
                    if (hit) tgt_m[d][i] <= cv;
                    if (cur_m[d][i] != tgt_m[d][i]) anyneq = 1'b1;
                end
                busy_m[d] <= anyneq;
            end
            ready_m <= !(i_load_valid && ready_m);
            pend_m  <= i_load_valid && ready_m;
            if (i_load_valid && ready_m) begin
                p_basic <= i_load_is_basic;
                p_idx   <= int'(i_load_index);
                p_val   <= int'(i_load_value);
                p_inst  <= i_load_instant;
            end
            edge_m <= edge_m + 1;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge i_clk) begin
        check("ready_a", {31'b0, rdy_a}, {31'b0, ready_m});
        check("ready_b", {31'b0, rdy_b}, {31'b0, ready_m});
        check("busy_a", {31'b0, busy_a}, {31'b0, busy_m[0]});
        check("busy_b", {31'b0, busy_b}, {31'b0, busy_m[1]});
        check("red_a", red_a, exp_bus(0, 0));
        check("green_a", green_a, exp_bus(0, 1));
        check("blue_a", blue_a, exp_bus(0, 2));
        check("basic_a", basic_a, exp_bus(0, 3));
        check("red_b", {8'h0, red_b}, exp_bus(1, 0));
        check("green_b", {8'h0, green_b}, exp_bus(1, 1));
        check("blue_b", {8'h0, blue_b}, exp_bus(1, 2));
        check("basic_b", basic_b, exp_bus(1, 3));
    end

    // ---------------- stimulus ----------------
    // Call at a negedge; returns at the negedge after the accepting edge, valid left high
    task automatic do_load(input bit b, input int idx, input logic [23:0] v, input bit inst);
        int w;
        w = 0;
        i_load_is_basic = b;
        i_load_index    = 2'(idx);
        i_load_value    = v;
        i_load_instant  = inst;
        i_load_valid    = 1'b1;
        while (!rdy_a && w < 10) begin
            @(negedge i_clk);
            w++;
        end
        if (w >= 10) check("load_timeout", 32'(w), 32'd0);
        @(negedge i_clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_red_a"}, red_a, 32'h0);
        check({tag, "_basic_a"}, basic_a, 32'h0);
        check({tag, "_green_b"}, {8'h0, green_b}, 32'h0);
        check({tag, "_ready"}, {31'b0, rdy_a}, 32'h0);
        check({tag, "_busy"}, {31'b0, busy_a | busy_b}, 32'h0);
    endtask

    initial begin
        logic [7:0] q[3];
        logic [7:0] prev;
        int nq, w;

        // Reset and release between edges
        @(negedge i_clk);
        @(negedge i_clk);
        #2 i_arst_n = 1'b1;
        #1 check_reset_outputs("rst_release");
        @(negedge i_clk);
        check("ready_first_edge", {31'b0, rdy_a}, 32'h1);

        // Colour LED 1 fades to 0x0A0300 with step 1
        do_load(1'b0, 1, 24'h0A0300, 1'b0);
        i_load_valid = 1'b0;
        @(negedge i_clk);
        check("s2_red_after_commit", {24'h0, red_a[15:8]}, 32'h0);
        repeat (48) @(negedge i_clk);
        check("s2_red_final", {24'h0, red_a[15:8]}, 32'h0A);
        check("s2_green_final", {24'h0, green_a[15:8]}, 32'h03);
        check("s2_blue", blue_a, 32'h0);
        check("s2_busy_done", {31'b0, busy_a}, 32'h0);

        // Instant basic load
        do_load(1'b1, 2, 24'hFFFF80, 1'b1);
        i_load_valid = 1'b0;
        @(negedge i_clk);
        check("s3_basic_a", basic_a, 32'h00800000);
        check("s3_basic_b", basic_b, 32'h00800000);
        repeat (4) begin
            @(negedge i_clk);
            check("s3_busy_a", {31'b0, busy_a}, 32'h0);
        end

        // Step 16 downward fade from 0x25 on dut_b
        do_load(1'b0, 0, 24'h250000, 1'b1);
        i_load_valid = 1'b0;
        @(negedge i_clk);
        check("s4_instant", {24'h0, red_b[7:0]}, 32'h25);
        do_load(1'b0, 0, 24'h000000, 1'b0);
        i_load_valid = 1'b0;
        prev = 8'h25;
        nq   = 0;
        for (int i = 0; i < 3; i++) q[i] = 8'hFF;
        repeat (24) begin
            @(negedge i_clk);
            if (red_b[7:0] != prev) begin
                if (nq < 3) q[nq] = red_b[7:0];
                nq++;
                prev = red_b[7:0];
            end
        end
        check("s4_changes", 32'(nq), 32'd3);
        check("s4_tick1", {24'h0, q[0]}, 32'h15);
        check("s4_tick2", {24'h0, q[1]}, 32'h05);
        check("s4_tick3", {24'h0, q[2]}, 32'h00);

        // Out-of-range colour index on dut_b is dropped
        w = 0;
        while (busy_b && w < 100) begin
            @(negedge i_clk);
            w++;
        end
        check("s6_settle", {31'b0, busy_b}, 32'h0);
        do_load(1'b0, 3, 24'hFFFFFF, 1'b0);
        i_load_valid = 1'b0;
        repeat (12) @(negedge i_clk);
        check("s6_busy_b", {31'b0, busy_b}, 32'h0);
        check("s6_red_b", {8'h0, red_b}, 32'h000A00);
        check("s6_green_b", {8'h0, green_b}, 32'h000300);
        check("s6_blue_b", {8'h0, blue_b}, 32'h0);
        check("s6_basic_b", basic_b, 32'h00800000);

        // Back-to-back loads with valid held high
        do_load(1'b0, 2, 24'h112233, 1'b0);
        do_load(1'b1, 0, 24'h000044, 1'b1);
        i_load_valid = 1'b0;
        @(negedge i_clk);
        check("s5_second_commit", {24'h0, basic_a[7:0]}, 32'h44);

        // Randomized loads
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 3) != 0) begin
                i_load_valid = 1'b0;
                repeat ($urandom_range(0, 6)) @(negedge i_clk);
            end
            do_load(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    24'($urandom), ($urandom_range(0, 3) == 0));
        end

        // Async reset during a commit cycle, mid-fade
        do_load(1'b0, 2, 24'hFFFFFF, 1'b1);
        i_load_valid = 1'b0;
        #1 i_arst_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        @(negedge i_clk);
        @(negedge i_clk);
        #2 i_arst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        check("rst_discard_red", red_a, 32'h0);
        check("rst_discard_green", green_a, 32'h0);

        repeat (40) begin
            do_load(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    24'($urandom), ($urandom_range(0, 1) == 0));
            i_load_valid = 1'b0;
            repeat ($urandom_range(0, 8)) @(negedge i_clk);
        end
        repeat (8) @(negedge i_clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, %0d failed so far", fails);
        $fatal(1);
    end
endmodule
